// File: rtl/io_host_loader.sv
// Host-side sequencer for the chip's pin-level load/readback protocol.
// Turns word commands into control lines, data-bus values, an I/O clock pulse, or a timed RUN.
module io_host_loader #(
  parameter int HALF  = 2,
  parameter int BLANK = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] pin_data_out,
  input  logic [15:0] pin_data_in,
  output logic        pin_wr_rdb,
  output logic        pin_addr_memb,
  output logic        pin_instr_datab,
  output logic        pin_start,
  output logic        pin_clk,
  input  logic        pin_hlt,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, RESP, RUN} state_t;

  localparam logic [2:0]  OP_SET_DADDR = 3'd0;
  localparam logic [2:0]  OP_SET_IADDR = 3'd1;
  localparam logic [2:0]  OP_WR_DATA   = 3'd2;
  localparam logic [2:0]  OP_WR_INSTR  = 3'd3;
  localparam logic [2:0]  OP_RD_DATA   = 3'd4;
  localparam logic [2:0]  OP_RD_INSTR  = 3'd5;
  localparam logic [2:0]  OP_RUN       = 3'd6;
  localparam logic [2:0]  OP_RD_ADDR   = 3'd7;
  localparam logic [3:0]  HALF_M1      = 4'(HALF - 1);
  localparam logic [19:0] BLANK_C      = 20'(BLANK);

  state_t      r_state;
  logic [2:0]  r_op;
  logic [15:0] r_data;
  logic [3:0]  r_half;
  logic [19:0] r_cnt;
  logic        r_hlt_meta;
  logic        r_hlt_s;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_err;
  logic [15:0] r_dout;
  logic        r_wr;
  logic        r_addr;
  logic        r_instr;
  logic        r_start;
  logic        r_pclk;

  logic [19:0] w_limit;
  logic        w_timeout;
  logic        w_hlt_seen;
  logic        w_is_read;
  logic [15:0] w_cnt_sat;

  // {wr_rdb, addr_memb, instr_datab} for each pin-cycle op.
  function automatic logic [2:0] opCtrl(input logic [2:0] op, input logic sel);
    case (op)
      OP_SET_DADDR: opCtrl = 3'b110;
      OP_SET_IADDR: opCtrl = 3'b111;
      OP_WR_DATA:   opCtrl = 3'b100;
      OP_WR_INSTR:  opCtrl = 3'b101;
      OP_RD_DATA:   opCtrl = 3'b000;
      OP_RD_INSTR:  opCtrl = 3'b001;
      OP_RD_ADDR:   opCtrl = {2'b01, sel};
      default:      opCtrl = 3'b000;
    endcase
  endfunction

  // The timeout counter is 20 bits wide so long limits work; the reported count saturates.
  assign w_limit    = {r_data, 4'h0};
  assign w_timeout  = (r_data != 16'h0000) && ((r_cnt + 20'd1) == w_limit);
  assign w_hlt_seen = r_hlt_s && (r_cnt >= BLANK_C);
  assign w_is_read  = (r_op == OP_RD_DATA) || (r_op == OP_RD_INSTR) || (r_op == OP_RD_ADDR);
  assign w_cnt_sat  = (r_cnt[19:16] != 4'h0) ? 16'hFFFF : r_cnt[15:0];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_op        <= 3'd0;
      r_data      <= 16'h0000;
      r_half      <= 4'd0;
      r_cnt       <= 20'd0;
      r_hlt_meta  <= 1'b0;
      r_hlt_s     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_err   <= 1'b0;
      r_dout      <= 16'h0000;
      r_wr        <= 1'b0;
      r_addr      <= 1'b0;
      r_instr     <= 1'b0;
      r_start     <= 1'b0;
      r_pclk      <= 1'b0;
    end else begin
      r_hlt_meta  <= pin_hlt;
      r_hlt_s     <= r_hlt_meta;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op       <= cmd_op;
            r_data     <= cmd_data;
            r_rsp_data <= cmd_data;
            r_rsp_err  <= 1'b0;
            r_half     <= 4'd0;
            if (cmd_op == OP_RUN) begin
              r_start <= 1'b1;
              r_cnt   <= 20'd0;
              r_state <= RUN;
            end else begin
              r_dout                   <= cmd_data;
              {r_wr, r_addr, r_instr}  <= opCtrl(cmd_op, cmd_data[0]);
              r_state                  <= SETUP;
            end
          end
        end
        SETUP: begin
          if (r_half == HALF_M1) begin
            r_half <= 4'd0;
            if (w_is_read) r_rsp_data <= pin_data_in;
            // Address readback must not pulse the I/O clock, or the chip would advance.
            if (r_op == OP_RD_ADDR) begin
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_pclk  <= 1'b1;
              r_state <= HIGH;
            end
          end else begin
            r_half <= r_half + 4'd1;
          end
        end
        HIGH: begin
          if (r_half == HALF_M1) begin
            r_half      <= 4'd0;
            r_pclk      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_half <= r_half + 4'd1;
          end
        end
        RESP: begin
          r_dout    <= 16'h0000;
          r_wr      <= 1'b0;
          r_addr    <= 1'b0;
          r_instr   <= 1'b0;
          r_rsp_err <= 1'b0;
          r_state   <= IDLE;
        end
        RUN: begin
          if (r_cnt != 20'hFFFFF) r_cnt <= r_cnt + 20'd1;
          if (w_hlt_seen) begin
            r_rsp_data  <= w_cnt_sat;
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_timeout) begin
            r_rsp_data  <= 16'hFFFF;
            r_rsp_err   <= 1'b1;
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready       = (r_state == IDLE);
  assign busy            = (r_state != IDLE);
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign rsp_err         = r_rsp_err;
  assign pin_data_out    = r_dout;
  assign pin_wr_rdb      = r_wr;
  assign pin_addr_memb   = r_addr;
  assign pin_instr_datab = r_instr;
  assign pin_start       = r_start;
  assign pin_clk         = r_pclk;

endmodule

// File: tb/tb_io_host_loader.sv
// Bench for io_host_loader: a small chip-side memory model, a table of pin-cycle commands,
// a response scoreboard, and hand-written RUN and reset sequences.
module tb_io_host_loader;

  localparam int HALF  = 2;
  localparam int BLANK = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_data = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] pin_data_out;
  logic [15:0] pin_data_in;
  logic        pin_wr_rdb, pin_addr_memb, pin_instr_datab;
  logic        pin_start, pin_clk;
  logic        pin_hlt = 1'b0;
  logic        busy;

  always #5 wb_clk_i = ~wb_clk_i;

  io_host_loader #(.HALF(HALF), .BLANK(BLANK)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pin_data_out(pin_data_out), .pin_data_in(pin_data_in),
    .pin_wr_rdb(pin_wr_rdb), .pin_addr_memb(pin_addr_memb), .pin_instr_datab(pin_instr_datab),
    .pin_start(pin_start), .pin_clk(pin_clk), .pin_hlt(pin_hlt), .busy(busy)
  );

  int nVec = 0;
  int nMiss = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Chip model: 8-bit data address, 16-bit instruction address, auto-increment on non-load edges.
  logic [15:0] dmem [0:255];
  logic [15:0] imem [0:255];
  logic [7:0]  mDaddr = 8'h00;
  logic [15:0] mIaddr = 16'h0000;
  int          clkRises = 0;
  logic [18:0] hiSnap = '0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 16'hD000 + 16'(i);
      imem[i] = 16'h0000;
    end
  end

  assign pin_data_in = (!pin_wr_rdb && pin_addr_memb) ?
                         (pin_instr_datab ? mIaddr : {8'h00, mDaddr}) :
                         (pin_instr_datab ? imem[mIaddr[7:0]] : dmem[mDaddr]);

  always @(posedge pin_clk) begin
    clkRises++;
    hiSnap = {pin_wr_rdb, pin_addr_memb, pin_instr_datab, pin_data_out};
    if (pin_wr_rdb && pin_addr_memb) begin
      if (pin_instr_datab) mIaddr = pin_data_out;
      else                 mDaddr = pin_data_out[7:0];
    end else begin
      if (pin_wr_rdb) begin
        if (pin_instr_datab) imem[mIaddr[7:0]] = pin_data_out;
        else                 dmem[mDaddr] = pin_data_out;
      end
      if (pin_instr_datab) mIaddr = mIaddr + 16'd1;
      else                 mDaddr = mDaddr + 8'd1;
    end
  end

  always @(negedge pin_clk) begin
    if (!wb_rst_i)
      checkOutput("ctrl/data stable while pin_clk high",
                  {13'h0, pin_wr_rdb, pin_addr_memb, pin_instr_datab, pin_data_out}, {13'h0, hiSnap});
  end

  // Halt model: either raise hlt a fixed number of cycles after start, or pulse it inside the blank window.
  int hltDelay = -1;
  bit blankPulse = 1'b0;

  always @(posedge pin_start) begin
    if (hltDelay >= 0) begin
      repeat (hltDelay) @(posedge wb_clk_i);
      #1 pin_hlt = 1'b1;
    end else if (blankPulse) begin
      #1 pin_hlt = 1'b1;
      @(posedge wb_clk_i);
      #1 pin_hlt = 1'b0;
    end
  end

  // Response scoreboard: expected entries pushed at issue, popped when rsp_valid is seen.
  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t sbHead;

  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && rsp_valid) begin
      if (sb.size() == 0) begin
        nVec++;
        nMiss++;
        $display("[TB] FAIL unexpected rsp: got data 0x%0h err %0b, want no response", rsp_data, rsp_err);
      end else begin
        sbHead = sb.pop_front();
        nVec++;
        if (rsp_data < sbHead.lo || rsp_data > sbHead.hi) begin
          nMiss++;
          $display("[TB] FAIL rsp_data: got 0x%0h, want 0x%0h..0x%0h", rsp_data, sbHead.lo, sbHead.hi);
        end
        checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, sbHead.err});
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] data,
                               input logic [15:0] lo, input logic [15:0] hi, input logic err,
                               input logic [2:0] expCtrl, input int lat, input int rises,
                               input logic chkCtrl);
    int   n;
    int   r0;
    exp_t e;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    checkOutput("cmd_ready before issue", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    e.lo = lo;
    e.hi = hi;
    e.err = err;
    sb.push_back(e);
    @(posedge wb_clk_i);
    r0 = clkRises;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    checkOutput("busy after accept", {31'h0, busy}, 32'h1);
    if (chkCtrl) begin
      checkOutput("ctrl lines after accept",
                  {29'h0, pin_wr_rdb, pin_addr_memb, pin_instr_datab}, {29'h0, expCtrl});
      checkOutput("pin_data_out after accept", {16'h0, pin_data_out}, {16'h0, data});
    end
    n = 1;
    while (!rsp_valid && n < 600) begin
      @(negedge wb_clk_i);
      n++;
    end
    checkOutput("rsp_valid seen within budget", {31'h0, rsp_valid}, 32'h1);
    if (lat > 0) checkOutput("rsp latency", n, lat);
    checkOutput("pin_clk pulses", clkRises - r0, rises);
    checkOutput("pin_start on rsp cycle", {31'h0, pin_start}, 32'h0);
    @(negedge wb_clk_i);
    checkOutput("cmd_ready after rsp", {31'h0, cmd_ready}, 32'h1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic [15:0] expData;
    logic [2:0]  expCtrl;
    int          lat;
    int          rises;
  } vec_t;
  vec_t vecs[14];

  localparam int LPIN  = 2 * HALF + 1;
  localparam int LADDR = HALF + 1;

  initial begin
    int seen;
    int n;
    vecs[0]  = '{3'd1, 16'h0010, 16'h0010, 3'b111, LPIN, 1};
    vecs[1]  = '{3'd3, 16'h2004, 16'h2004, 3'b101, LPIN, 1};
    vecs[2]  = '{3'd3, 16'hABCD, 16'hABCD, 3'b101, LPIN, 1};
    vecs[3]  = '{3'd0, 16'h00FF, 16'h00FF, 3'b110, LPIN, 1};
    vecs[4]  = '{3'd2, 16'h1234, 16'h1234, 3'b100, LPIN, 1};
    vecs[5]  = '{3'd0, 16'h00FF, 16'h00FF, 3'b110, LPIN, 1};
    vecs[6]  = '{3'd4, 16'h0000, 16'h1234, 3'b000, LPIN, 1};
    vecs[7]  = '{3'd4, 16'h0000, 16'hD000, 3'b000, LPIN, 1};
    vecs[8]  = '{3'd1, 16'h1FFF, 16'h1FFF, 3'b111, LPIN, 1};
    vecs[9]  = '{3'd7, 16'h0001, 16'h1FFF, 3'b011, LADDR, 0};
    vecs[10] = '{3'd1, 16'h0010, 16'h0010, 3'b111, LPIN, 1};
    vecs[11] = '{3'd5, 16'h0000, 16'h2004, 3'b001, LPIN, 1};
    vecs[12] = '{3'd5, 16'h0000, 16'hABCD, 3'b001, LPIN, 1};
    vecs[13] = '{3'd7, 16'h0000, 16'h0001, 3'b010, LADDR, 0};

    repeat (2) @(negedge wb_clk_i);
    checkOutput("reset cmd_ready", {31'h0, cmd_ready}, 32'h1);
    checkOutput("reset busy", {31'h0, busy}, 32'h0);
    checkOutput("reset rsp_valid/err", {30'h0, rsp_valid, rsp_err}, 32'h0);
    checkOutput("reset rsp_data", {16'h0, rsp_data}, 32'h0);
    checkOutput("reset pins", {27'h0, pin_wr_rdb, pin_addr_memb, pin_instr_datab, pin_start, pin_clk}, 32'h0);
    checkOutput("reset pin_data_out", {16'h0, pin_data_out}, 32'h0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].expData, vecs[i].expData, 1'b0,
                    vecs[i].expCtrl, vecs[i].lat, vecs[i].rises, 1'b1);

    checkOutput("chip imem[0x10]", {16'h0, imem[8'h10]}, 32'h2004);
    checkOutput("chip imem[0x11]", {16'h0, imem[8'h11]}, 32'hABCD);
    checkOutput("chip dmem[0xFF]", {16'h0, dmem[8'hFF]}, 32'h1234);

    // RUN ended by hlt 100 cycles after start: count 102, rsp four cycles after hlt rises.
    hltDelay = 100;
    applyStimulus(3'd6, 16'h0010, 16'd102, 16'd104, 1'b0, 3'b000, 104, 0, 1'b0);
    hltDelay = -1;
    pin_hlt = 1'b0;
    repeat (3) @(negedge wb_clk_i);

    // RUN with a 16-cycle timeout and a hlt pulse inside the blank window that must be ignored.
    blankPulse = 1'b1;
    applyStimulus(3'd6, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b1, 3'b000, 17, 0, 1'b0);
    blankPulse = 1'b0;

    // Reset while pin_clk is high during WR_DATA: everything drops at once, no response.
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_data  = 16'h5555;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    n = 0;
    while (!pin_clk && n < 20) begin
      @(negedge wb_clk_i);
      n++;
    end
    checkOutput("pin_clk high before reset", {31'h0, pin_clk}, 32'h1);
    #1 wb_rst_i = 1'b1;
    #1;
    checkOutput("pin_clk in reset", {31'h0, pin_clk}, 32'h0);
    checkOutput("pin_wr_rdb in reset", {31'h0, pin_wr_rdb}, 32'h0);
    checkOutput("busy in reset", {31'h0, busy}, 32'h0);
    checkOutput("rsp_valid in reset", {31'h0, rsp_valid}, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    seen = 0;
    repeat (4 * HALF + 4) begin
      @(negedge wb_clk_i);
      if (rsp_valid) seen++;
    end
    checkOutput("rsp after aborted cmd", seen, 0);
    checkOutput("cmd_ready after reset release", {31'h0, cmd_ready}, 32'h1);
    checkOutput("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
